// File: rtl/uart_mmio_fifo_if.sv
// Register bus between a host and the UART: active-low one-cycle strobes,
// a 2-bit register select, write data in and registered read data out.
interface uart_mmio_fifo_if;
  logic       rd;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] in_data;
  logic [7:0] out_data;

  modport master (output rd, output wr, output addr, output in_data, input out_data);
  modport slave  (input rd, input wr, input addr, input in_data, output out_data);
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with 2^FIFO_AW-deep TX and RX FIFOs, a programmable
// divisor (bit period = (DIV+1)*PRESCALE clocks), sticky error flags and an irq.
// PRESCALE*(256) must fit the 16-bit bit-period counters.
module uart_mmio_fifo #(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned RESET_DIV = 107
) (
  input  logic             clock,
  input  logic             reset,
  uart_mmio_fifo_if.slave  bus,
  input  logic             rx_in,
  output logic             tx_out,
  output logic             irq
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} uart_state_e;

  logic [7:0] ctrl_q, ctrl_d, div_q, div_d, out_data_q, out_data_d;
  logic       ovr_q, ovr_d, frm_q, frm_d, drop_q, drop_d, irq_q, irq_d, tx_out_q, tx_out_d;
  logic [FIFO_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0] tx_mem_q [DEPTH];
  logic [7:0] rx_mem_q [DEPTH];
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d, rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        tx_stop2_q, tx_stop2_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rd_s, wr_s, tx_flush_s, rx_flush_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tx_busy_s, ovr_set_s, frm_set_s;
  logic [7:0]  status_s;
  logic [15:0] bit_len_s;

  assign rd_s       = ~bus.rd;
  assign wr_s       = ~bus.wr;
  assign tx_flush_s = wr_s && (bus.addr == 2'd0) && bus.in_data[4];
  assign rx_flush_s = wr_s && (bus.addr == 2'd0) && bus.in_data[5];
  assign tx_empty_s = (tx_wp_q == tx_rp_q);
  assign rx_empty_s = (rx_wp_q == rx_rp_q);
  assign tx_full_s  = ((tx_wp_q ^ tx_rp_q) == {1'b1, {FIFO_AW{1'b0}}});
  assign rx_full_s  = ((rx_wp_q ^ rx_rp_q) == {1'b1, {FIFO_AW{1'b0}}});
  assign rx_pop_s   = rd_s && (bus.addr == 2'd2) && !rx_empty_s;
  assign tx_busy_s  = (tx_state_q != S_IDLE);
  assign status_s   = {drop_q, tx_busy_s, frm_q, ovr_q, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
  assign bit_len_s  = 16'((32'(div_q) + 32'd1) * PRESCALE);
  assign bus.out_data = out_data_q;
  assign tx_out     = tx_out_q;
  assign irq        = irq_q;

  // Register writes, read mux, sticky flags, FIFO pointers and irq
  always_comb begin
    ctrl_d = ctrl_q;  div_d = div_q;  out_data_d = out_data_q;
    ovr_d = ovr_q;  frm_d = frm_q;  drop_d = drop_q;  tx_push_s = 1'b0;
    if (wr_s) begin
      case (bus.addr)
        2'd0:    ctrl_d = {1'b0, bus.in_data[6], 2'b00, bus.in_data[3:0]};
        2'd1:    begin
                   ovr_d  = ovr_q  & ~bus.in_data[4];
                   frm_d  = frm_q  & ~bus.in_data[5];
                   drop_d = drop_q & ~bus.in_data[7];
                 end
        2'd2:    if (!tx_full_s || tx_pop_s) tx_push_s = 1'b1; else drop_d = 1'b1;
        2'd3:    div_d = bus.in_data;
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    ovr_d = ovr_d | ovr_set_s;
    frm_d = frm_d | frm_set_s;
    if (rd_s) begin
      case (bus.addr)
        2'd0:    out_data_d = ctrl_q;
        2'd1:    out_data_d = status_s;
        2'd2:    out_data_d = rx_empty_s ? 8'h00 : rx_mem_q[rx_rp_q[FIFO_AW-1:0]];
        2'd3:    out_data_d = div_q;
        default: out_data_d = 8'h00;
      endcase
    end else begin
      out_data_d = out_data_q;
    end
    tx_wp_d = tx_wp_q + {{FIFO_AW{1'b0}}, tx_push_s};
    tx_rp_d = tx_rp_q + {{FIFO_AW{1'b0}}, tx_pop_s};
    rx_wp_d = rx_wp_q + {{FIFO_AW{1'b0}}, rx_push_s};
    rx_rp_d = rx_rp_q + {{FIFO_AW{1'b0}}, rx_pop_s};
    if (tx_flush_s) begin tx_wp_d = '0; tx_rp_d = '0; end else begin tx_wp_d = tx_wp_d; end
    if (rx_flush_s) begin rx_wp_d = '0; rx_rp_d = '0; end else begin rx_wp_d = rx_wp_d; end
    irq_d = (ctrl_q[2] & ~rx_empty_s) | (ctrl_q[3] & tx_empty_s);
  end

  // Transmitter: start/data/stop sequencing, frame starts only with tx_en and data queued
  always_comb begin
    tx_state_d = tx_state_q;  tx_cnt_d = tx_cnt_q;  tx_bit_d = tx_bit_q;  tx_len_d = tx_len_q;
    tx_shift_d = tx_shift_q;  tx_stop2_d = tx_stop2_q;  tx_out_d = tx_out_q;  tx_pop_s = 1'b0;
    case (tx_state_q)
      S_IDLE: if (ctrl_q[0] && !tx_empty_s && !tx_flush_s) begin
                tx_pop_s = 1'b1;  tx_shift_d = tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
                tx_len_d = bit_len_s;  tx_stop2_d = ctrl_q[6];  tx_cnt_d = 16'd0;
                tx_bit_d = 3'd0;  tx_state_d = S_START;  tx_out_d = 1'b0;
              end else begin
                tx_out_d = 1'b1;
              end
      S_START: if (tx_cnt_q == tx_len_q - 16'd1) begin
                 tx_cnt_d = 16'd0;  tx_state_d = S_DATA;  tx_out_d = tx_shift_q[0];
               end else begin
                 tx_cnt_d = tx_cnt_q + 16'd1;
               end
      S_DATA: if (tx_cnt_q == tx_len_q - 16'd1) begin
                tx_cnt_d = 16'd0;
                if (tx_bit_q == 3'd7) begin
                  tx_state_d = S_STOP;  tx_bit_d = 3'd0;  tx_out_d = 1'b1;
                end else begin
                  tx_bit_d = tx_bit_q + 3'd1;  tx_shift_d = {1'b0, tx_shift_q[7:1]};  tx_out_d = tx_shift_q[1];
                end
              end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
              end
      S_STOP: if (tx_cnt_q == tx_len_q - 16'd1) begin
                tx_cnt_d = 16'd0;
                if (tx_stop2_q && (tx_bit_q == 3'd0)) tx_bit_d = 3'd1; else tx_state_d = S_IDLE;
              end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
              end
      default: begin tx_state_d = S_IDLE;  tx_out_d = 1'b1; end
    endcase
  end

  // Receiver: falling-edge start, half-bit confirm, centre sampling, stop-bit check
  always_comb begin
    rx_state_d = rx_state_q;  rx_cnt_d = rx_cnt_q;  rx_bit_d = rx_bit_q;  rx_len_d = rx_len_q;
    rx_shift_d = rx_shift_q;  rx_push_s = 1'b0;  ovr_set_s = 1'b0;  frm_set_s = 1'b0;
    case (rx_state_q)
      S_IDLE: if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;  rx_cnt_d = 16'd0;  rx_len_d = bit_len_s;
              end else begin
                rx_cnt_d = 16'd0;
              end
      S_START: if (rx_cnt_q + 16'd1 >= {1'b0, rx_len_q[15:1]}) begin
                 rx_cnt_d = 16'd0;  rx_bit_d = 3'd0;
                 rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               end else begin
                 rx_cnt_d = rx_cnt_q + 16'd1;
               end
      S_DATA: if (rx_cnt_q == rx_len_q - 16'd1) begin
                rx_cnt_d = 16'd0;  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP; else rx_bit_d = rx_bit_q + 3'd1;
              end else begin
                rx_cnt_d = rx_cnt_q + 16'd1;
              end
      S_STOP: if (rx_cnt_q == rx_len_q - 16'd1) begin
                rx_state_d = S_IDLE;  rx_cnt_d = 16'd0;
                if (!rx_s2_q) frm_set_s = 1'b1;
                else if (rx_full_s && !rx_pop_s) ovr_set_s = 1'b1;
                else rx_push_s = 1'b1;
              end else begin
                rx_cnt_d = rx_cnt_q + 16'd1;
              end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO storage writes (contents need no reset; pointers define validity)
  always_ff @(posedge clock) begin
    if (tx_push_s) tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= bus.in_data;
    if (rx_push_s) rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= rx_shift_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_q <= 8'h00;  div_q <= 8'(RESET_DIV);  out_data_q <= 8'h00;
      ovr_q <= 1'b0;  frm_q <= 1'b0;  drop_q <= 1'b0;  irq_q <= 1'b0;  tx_out_q <= 1'b1;
      tx_wp_q <= '0;  tx_rp_q <= '0;  rx_wp_q <= '0;  rx_rp_q <= '0;
      tx_state_q <= S_IDLE;  tx_cnt_q <= 16'd0;  tx_len_q <= 16'd0;  tx_bit_q <= 3'd0;
      tx_shift_q <= 8'h00;  tx_stop2_q <= 1'b0;
      rx_state_q <= S_IDLE;  rx_cnt_q <= 16'd0;  rx_len_q <= 16'd0;  rx_bit_q <= 3'd0;
      rx_shift_q <= 8'h00;  rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
    end else begin
      ctrl_q <= ctrl_d;  div_q <= div_d;  out_data_q <= out_data_d;
      ovr_q <= ovr_d;  frm_q <= frm_d;  drop_q <= drop_d;  irq_q <= irq_d;  tx_out_q <= tx_out_d;
      tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_len_q <= tx_len_d;  tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;  tx_stop2_q <= tx_stop2_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_len_q <= rx_len_d;  rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;  rx_s1_q <= rx_in;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: register reads push their expected value into a
// scoreboard queue; a monitor pops and compares when read data is presented.
module tb_uart_mmio_fifo;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx_in, tx_out, irq;
  logic loop_en = 1'b1;
  logic rx_drive = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct { logic [7:0] val; string name; } exp_t;
  exp_t exp_q[$];
  logic rd_seen = 1'b0;

  uart_mmio_fifo_if ifc ();

  uart_mmio_fifo dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (ifc),
    .rx_in  (rx_in),
    .tx_out (tx_out),
    .irq    (irq)
  );

  assign rx_in = loop_en ? tx_out : rx_drive;
  always #5 clock = ~clock;

  // A read strobe seen at this edge means out_data is valid after it
  always @(posedge clock) rd_seen <= (ifc.rd === 1'b0);

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t e;
    if (rd_seen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: out_data=%h with nothing expected", ifc.out_data);
      end else begin
        e = exp_q.pop_front();
        if (ifc.out_data !== e.val) begin
          n_fail++;
          $display("FAIL %s: out_data=%h expected %h", e.name, ifc.out_data, e.val);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock); ifc.addr = a; ifc.in_data = d; ifc.wr = 1'b0;
    @(negedge clock); ifc.wr = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [7:0] expv, input string name);
    exp_t e;
    e.val = expv; e.name = name;
    exp_q.push_back(e);
    @(negedge clock); ifc.addr = a; ifc.rd = 1'b0;
    @(negedge clock); ifc.rd = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_tx_low(input string name);
    for (int k = 0; k < 40 && tx_out !== 1'b0; k++) @(negedge clock);
    chk(name, {7'd0, tx_out}, 8'h00);
  endtask

  // Drive one serial frame on rx_in at 4 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clock); rx_drive = 1'b0;
    wait_cycles(4);
    for (int i = 0; i < 8; i++) begin rx_drive = b[i]; wait_cycles(4); end
    rx_drive = stop; wait_cycles(4);
    rx_drive = 1'b1; wait_cycles(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5;
    logic       expbit;
    ifc.rd = 1'b1; ifc.wr = 1'b1; ifc.addr = 2'd0; ifc.in_data = 8'h00;
    a5 = 8'hA5;
    // Reset state
    wait_cycles(3);
    chk("rst_tx_out", {7'd0, tx_out}, 8'h01);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    reset = 1'b1;
    bus_rd(2'd1, 8'h05, "rst_status");
    bus_rd(2'd0, 8'h00, "rst_ctrl");
    bus_rd(2'd3, 8'h6B, "rst_div");
    bus_rd(2'd2, 8'h00, "empty_data_read");
    bus_rd(2'd1, 8'h05, "status_after_empty_read");

    // TX waveform of 0xA5 at DIV=0
    bus_wr(2'd3, 8'h00);
    bus_rd(2'd3, 8'h00, "div_write");
    bus_wr(2'd0, 8'h01);
    bus_wr(2'd2, 8'hA5);
    wait_tx_low("tx_start_timeout");
    for (int k = 0; k < 40; k++) begin
      if (k < 4) expbit = 1'b0;
      else if (k < 36) expbit = a5[(k - 4) / 4];
      else expbit = 1'b1;
      chk($sformatf("tx_wave_%0d", k), {7'd0, tx_out}, {7'd0, expbit});
      @(negedge clock);
    end
    wait_cycles(4);
    bus_rd(2'd1, 8'h05, "tx_done_status");

    // Loopback receive of 0x3C
    bus_wr(2'd0, 8'h03);
    bus_wr(2'd2, 8'h3C);
    wait_cycles(60);
    bus_rd(2'd1, 8'h04, "rx_one_status");
    bus_rd(2'd2, 8'h3C, "rx_data_3c");
    bus_rd(2'd1, 8'h05, "rx_drained_status");

    // Interrupts
    bus_wr(2'd0, 8'h07);
    wait_cycles(2);
    chk("irq_idle", {7'd0, irq}, 8'h00);
    bus_wr(2'd2, 8'h5A);
    wait_cycles(60);
    chk("irq_rx", {7'd0, irq}, 8'h01);
    bus_rd(2'd2, 8'h5A, "rx_data_5a");
    wait_cycles(2);
    chk("irq_cleared", {7'd0, irq}, 8'h00);
    bus_wr(2'd0, 8'h08);
    wait_cycles(2);
    chk("irq_tx_empty", {7'd0, irq}, 8'h01);

    // TX FIFO full, drop and flag clear, then flush
    bus_wr(2'd0, 8'h00);
    for (int i = 0; i < 16; i++) bus_wr(2'd2, 8'(i));
    bus_rd(2'd1, 8'h09, "tx_full_status");
    bus_wr(2'd2, 8'hFF);
    bus_rd(2'd1, 8'h89, "tx_drop_status");
    bus_wr(2'd1, 8'h80);
    bus_rd(2'd1, 8'h09, "tx_drop_cleared");
    bus_wr(2'd0, 8'h10);
    bus_rd(2'd1, 8'h05, "tx_flush_status");
    bus_rd(2'd0, 8'h00, "ctrl_flush_selfclear");

    // RX overrun: 17 frames without reading
    bus_wr(2'd0, 8'h03);
    for (int i = 0; i < 17; i++) bus_wr(2'd2, 8'(8'h10 + i));
    wait_cycles(17 * 42 + 60);
    bus_rd(2'd1, 8'h16, "rx_overrun_status");
    for (int i = 0; i < 16; i++) bus_rd(2'd2, 8'(8'h10 + i), $sformatf("rx_order_%0d", i));
    bus_rd(2'd1, 8'h15, "rx_overrun_drained");
    bus_wr(2'd1, 8'h10);
    bus_rd(2'd1, 8'h05, "rx_overrun_cleared");

    // Framing error then a good frame, driven directly
    loop_en = 1'b0;
    bus_wr(2'd0, 8'h02);
    send_rx(8'h81, 1'b0);
    bus_rd(2'd1, 8'h25, "frame_err_status");
    send_rx(8'h96, 1'b1);
    bus_rd(2'd1, 8'h24, "frame_good_status");
    bus_rd(2'd2, 8'h96, "frame_good_data");
    bus_wr(2'd1, 8'h20);
    bus_rd(2'd1, 8'h05, "frame_err_cleared");

    // Reset in the middle of a TX frame of all zeros
    loop_en = 1'b1;
    bus_wr(2'd0, 8'h01);
    bus_wr(2'd2, 8'h00);
    wait_tx_low("tx_start2_timeout");
    wait_cycles(10);
    chk("tx_mid_frame_low", {7'd0, tx_out}, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("tx_abort_on_reset", {7'd0, tx_out}, 8'h01);
    bus_rd(2'd1, 8'h05, "reset_mid_status");
    bus_rd(2'd0, 8'h00, "reset_mid_ctrl");
    bus_rd(2'd3, 8'h6B, "reset_mid_div");
    wait_cycles(4);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
